bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble, one bit per clock).
// Values above 9999 report all-F digits with ovf set, after the same fixed latency.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [3:0]  bcd3,
    output logic [3:0]  bcd2,
    output logic [3:0]  bcd1,
    output logic [3:0]  bcd0
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [13:0] sr_q, sr_d;
    logic [15:0] scr_q, scr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovfp_q, ovfp_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic [15:0] dig_q, dig_d;
    logic [29:0] step;

    function automatic logic [15:0] add3(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        ovfp_d  = ovfp_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        step    = {add3(scr_q), sr_q} << 1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bin;
                    scr_d   = 16'h0000;
                    cnt_d   = 4'd0;
                    ovfp_d  = (bin > 14'd9999);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = step[29:14];
                sr_d  = step[13:0];
                cnt_d = cnt_q + 4'd1;
                // Last iteration: publish the result on the same edge the final shift lands.
                if (cnt_q == 4'd13) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (ovfp_q) begin
                        dig_d = 16'hFFFF;
                        ovf_d = 1'b1;
                    end else begin
                        dig_d = step[29:14];
                        ovf_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= 14'h0000;
            scr_q   <= 16'h0000;
            cnt_q   <= 4'd0;
            ovfp_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dig_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            ovfp_q  <= ovfp_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign bcd3 = dig_q[15:12];
    assign bcd2 = dig_q[11:8];
    assign bcd1 = dig_q[7:4];
    assign bcd0 = dig_q[3:0];

endmodule
